// File: rtl/gray_cdc_pkg.sv
// Shared definitions for the Gray-code CDC path and its fast-domain consumer:
// default data width, Gray/binary conversion helpers and the decoder state type.
package gray_cdc_pkg;

  localparam int GRAY_WIDTH = 4;

  // Decoder state: waiting for the first accepted code, or tracking a sequence.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  // Operates on a zero-extended 32-bit value so any width up to 32 can use it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int s = 1; s < 32; s++) begin
      b = b ^ (g >> s);
    end
    return b;
  endfunction

  // Binary to Gray: adjacent-bit XOR.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_stable_filter.sv
// Stability filter: tracks the most recent input code and how many consecutive
// edges it has been seen, flagging the edge on which it becomes settled.
module gray_stable_filter #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clk_f,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] stable_code,
  output logic             stable_hit
);

  localparam logic [2:0] HOLD_MAX = 3'(STABLE_CYCLES);

  logic [WIDTH-1:0] cand;
  logic [2:0]       hold_cnt;
  logic [2:0]       hold_next;
  logic             code_changed;

  assign code_changed = (gray_in != cand);

  // Next hold count: a new code restarts at one, a repeated code counts up to the limit.
  always_comb begin
    hold_next = hold_cnt;
    if (code_changed) begin
      hold_next = 3'd1;
    end else if (hold_cnt != HOLD_MAX) begin
      hold_next = hold_cnt + 3'd1;
    end
  end

  // The hit fires only when the count arrives at the limit, not while parked there.
  // A code change with a limit of one is a fresh arrival even if the count was saturated.
  assign stable_hit  = (hold_next == HOLD_MAX) && (code_changed || (hold_cnt != HOLD_MAX));
  // Whenever a hit fires the candidate being registered this edge equals gray_in.
  assign stable_code = gray_in;

  // Candidate and hold-count registers.
  always_ff @(posedge clk_f) begin
    if (rst) begin
      cand     <= '0;
      hold_cnt <= 3'd0;
    end else begin
      if (code_changed) begin
        cand <= gray_in;
      end
      hold_cnt <= hold_next;
    end
  end

endmodule

// File: rtl/gray_rx_decoder.sv
// Fast-domain Gray-code consumer: accepts settled codes, converts them to binary,
// strobes each new value and checks that consecutive values advance by +1.
//
// Output handshake: bin_valid is a one-cycle strobe with no ready; bin_out and
// step_err are meaningful in the cycle bin_valid is high and the consumer must
// take them then. bin_out keeps its value until the next acceptance.
module gray_rx_decoder
  import gray_cdc_pkg::*;
#(
  parameter int WIDTH         = GRAY_WIDTH,
  parameter int STABLE_CYCLES = 2,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk_f,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     gray_in,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_valid,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 locked,
  output state_t               dbg_state
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] last_gray;
  logic [WIDTH-1:0] stable_code;
  logic             stable_hit;
  logic [WIDTH-1:0] bin_new;
  logic [WIDTH-1:0] bin_expected;
  logic             accept;

  gray_stable_filter #(
    .WIDTH        (WIDTH),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk_f      (clk_f),
    .rst        (rst),
    .gray_in    (gray_in),
    .stable_code(stable_code),
    .stable_hit (stable_hit)
  );

  assign bin_new      = WIDTH'(gray2bin(32'(stable_code)));
  assign bin_expected = bin_out + WIDTH'(1);
  // A settled code re-appearing after a glitch is not a new value once locked.
  assign accept       = stable_hit && ((state == ST_IDLE) || (stable_code != last_gray));
  assign dbg_state    = state;

  // Decoder FSM with registered strobes, step check and saturating error count.
  always_ff @(posedge clk_f) begin
    if (rst) begin
      state     <= ST_IDLE;
      last_gray <= '0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      step_err  <= 1'b0;
      err_cnt   <= '0;
      locked    <= 1'b0;
    end else begin
      bin_valid <= 1'b0;
      step_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            bin_out   <= bin_new;
            last_gray <= stable_code;
            bin_valid <= 1'b1;
            locked    <= 1'b1;
            state     <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (accept) begin
            bin_out   <= bin_new;
            last_gray <= stable_code;
            bin_valid <= 1'b1;
            if (bin_new != bin_expected) begin
              step_err <= 1'b1;
              if (err_cnt != ERR_MAX) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Directed bench for gray_rx_decoder: reset values, acceptance latency, sequential
// stepping, wrap-around, step errors, glitch rejection, saturation and reset recovery.
module tb_gray_rx_decoder;
  import gray_cdc_pkg::*;

  logic       clk_f = 1'b0;
  logic       rst;
  logic [3:0] gray_in;
  logic [3:0] bin_out;
  logic       bin_valid;
  logic       step_err;
  logic [7:0] err_cnt;
  logic       locked;
  state_t     dbg_state;

  int errors = 0;
  int checks = 0;

  gray_rx_decoder #(
    .WIDTH        (4),
    .STABLE_CYCLES(2),
    .ERR_CNT_W    (8)
  ) dut (
    .clk_f    (clk_f),
    .rst      (rst),
    .gray_in  (gray_in),
    .bin_out  (bin_out),
    .bin_valid(bin_valid),
    .step_err (step_err),
    .err_cnt  (err_cnt),
    .locked   (locked),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk_f = ~clk_f;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one code for one edge; outputs are sampled 1 time unit after the edge.
  task automatic tick(input logic [3:0] g);
    gray_in = g;
    @(posedge clk_f);
    #1;
  endtask

  // Hold code g for n edges; check strobe count, edge of the strobe, step errors and bin_out.
  task automatic hold_code(input string tag, input logic [3:0] g, input int n,
                           input int exp_valids, input int exp_edge,
                           input int exp_errs, input logic [3:0] exp_bin);
    int nv;
    int ne;
    int first_edge;
    nv = 0;
    ne = 0;
    first_edge = 0;
    for (int k = 1; k <= n; k++) begin
      tick(g);
      if (bin_valid === 1'b1) begin
        nv++;
        if (first_edge == 0) first_edge = k;
      end
      if (step_err === 1'b1) ne++;
    end
    check({tag, "_valids"}, nv, exp_valids);
    check({tag, "_errs"}, ne, exp_errs);
    if (exp_valids > 0) begin
      check({tag, "_edge"}, first_edge, exp_edge);
      check({tag, "_bin"}, bin_out, exp_bin);
    end
  endtask

  logic [3:0] g;
  logic [3:0] b;

  initial begin
    // Reset
    rst = 1'b1;
    gray_in = 4'b0000;
    tick(4'b0000);
    tick(4'b0000);
    check("rst_bin_out", bin_out, 0);
    check("rst_bin_valid", bin_valid, 0);
    check("rst_step_err", step_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_locked", locked, 0);
    check("rst_state", dbg_state, ST_IDLE);

    // First value: 0000 accepted on the 2nd edge after release
    rst = 1'b0;
    tick(4'b0000);
    check("first_e1_valid", bin_valid, 0);
    check("first_e1_locked", locked, 0);
    tick(4'b0000);
    check("first_e2_valid", bin_valid, 1);
    check("first_e2_bin", bin_out, 0);
    check("first_e2_locked", locked, 1);
    check("first_e2_step_err", step_err, 0);
    check("first_e2_state", dbg_state, ST_LOCKED);
    tick(4'b0000);
    check("first_e3_valid", bin_valid, 0);
    check("first_e3_locked", locked, 1);

    // Sequential steps, each held 3 edges
    hold_code("step1", 4'b0001, 3, 1, 2, 0, 4'd1);
    hold_code("step2", 4'b0011, 3, 1, 2, 0, 4'd2);
    hold_code("step3", 4'b0010, 3, 1, 2, 0, 4'd3);
    check("steps_err_cnt", err_cnt, 0);

    // Glitch 0010 -> 0110 (one edge) -> 0010: nothing reported
    hold_code("glitch", 4'b0110, 1, 0, 0, 0, 4'd0);
    hold_code("glitch_back", 4'b0010, 3, 0, 0, 0, 4'd0);
    check("glitch_bin_kept", bin_out, 3);

    // Jump 3 -> 6 (Gray 0101) held 2 edges: step error
    hold_code("jump", 4'b0101, 2, 1, 2, 1, 4'd6);
    check("jump_err_cnt", err_cnt, 1);

    // Continue 7..15, wrap to 0, then 1..15 and 0 again: all legal steps
    for (int i = 7; i <= 31 + 1; i++) begin
      b = 4'(i);
      g = b ^ (b >> 1);
      hold_code($sformatf("seq%0d", i), g, 2, 1, 2, 0, b);
    end
    check("seq_err_cnt", err_cnt, 1);
    check("seq_bin_end", bin_out, 0);

    // 300 step errors alternating binary 2 (Gray 0011) and 0 (Gray 0000)
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) hold_code("err_to2", 4'b0011, 2, 1, 2, 1, 4'd2);
      else            hold_code("err_to0", 4'b0000, 2, 1, 2, 1, 4'd0);
      if (i == 9) check("err_cnt_mid", err_cnt, 11);
    end
    check("err_cnt_sat", err_cnt, 255);

    // Reset with a candidate pending
    tick(4'b0101);
    check("pend_valid", bin_valid, 0);
    rst = 1'b1;
    tick(4'b0101);
    check("mid_rst_bin_out", bin_out, 0);
    check("mid_rst_valid", bin_valid, 0);
    check("mid_rst_step_err", step_err, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_state", dbg_state, ST_IDLE);

    // Recovery: the first post-reset edge is a fresh first sample
    rst = 1'b0;
    hold_code("recover", 4'b0101, 3, 1, 2, 0, 4'd6);
    check("recover_locked", locked, 1);
    check("recover_err_cnt", err_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
